// File: rtl/seq_sign_multiplier_pkg.sv
// Shared types and constants for the sequential signed multiplier.
package seq_sign_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic FMT_SM = 1'b0;  // sign-magnitude
  localparam logic FMT_TC = 1'b1;  // two's complement

  // Smallest bit count able to hold values 0..n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_sign_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
interface seq_sign_multiplier_if #(
  parameter int unsigned W = 5
) ();
  logic           start;
  logic           fmt;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;
  logic           sign;

  modport master (output start, fmt, a, b, input busy, done, prod, sign);
  modport slave  (input start, fmt, a, b, output busy, done, prod, sign);
endinterface

// File: rtl/seq_mul_step.sv
// One shift-add iteration: conditional add of the multiplicand, then a right shift of
// {carry, acc, mq} with zero entering at the top.
module seq_mul_step #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_mq,
  input  logic [W-1:0] i_mcand,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_mq
);
  logic [W:0] w_sum;

  // Add when the multiplier LSB is set, then shift the carry into the accumulator
  always_comb begin
    w_sum = {1'b0, i_acc};
    if (i_mq[0]) w_sum = {1'b0, i_acc} + {1'b0, i_mcand};
    o_acc = w_sum[W:1];
    o_mq  = {w_sum[0], i_mq[W-1:1]};
  end
endmodule

// File: rtl/seq_sign_multiplier.sv
// Sequential shift-add multiplier for sign-magnitude or two's-complement operands.
// One partial product per clock; result is available W+1 cycles after start.
module seq_sign_multiplier
  import seq_sign_multiplier_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  seq_sign_multiplier_if.slave bus
);
  localparam int unsigned      CntW = clog2(W);
  localparam logic [W-1:0]     OneW = W'(1);
  localparam logic [2*W-1:0]   OneP = (2*W)'(1);

  state_e         r_state, w_state_nxt;
  logic           r_fmt, r_sign_lat;
  logic [W-1:0]   r_mcand, r_mq, r_acc;
  logic [CntW-1:0] r_cnt;
  logic           r_busy, r_done, r_sign;
  logic [2*W-1:0] r_prod;

  logic [W-1:0]   w_mag_a, w_mag_b, w_acc_step, w_mq_step;
  logic [2*W-1:0] w_mag, w_prod_fix;
  logic           w_sign_fix, w_last;

  // Convert operands to unsigned magnitudes; -2^(W-1) maps to 2^(W-1) without overflow
  always_comb begin
    if (bus.fmt == FMT_TC) begin
      w_mag_a = bus.a[W-1] ? (~bus.a + OneW) : bus.a;
      w_mag_b = bus.b[W-1] ? (~bus.b + OneW) : bus.b;
    end else begin
      w_mag_a = {1'b0, bus.a[W-2:0]};
      w_mag_b = {1'b0, bus.b[W-2:0]};
    end
  end

  seq_mul_step #(.W(W)) u_step (
    .i_acc   (r_acc),
    .i_mq    (r_mq),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_step),
    .o_mq    (w_mq_step)
  );

  assign w_last = (r_cnt == CntW'(W - 1));

  // Apply the latched sign to the magnitude; zero is never reported as negative
  always_comb begin
    w_mag = {r_acc, r_mq};
    if (r_fmt == FMT_TC) begin
      w_prod_fix = (r_sign_lat && (w_mag != '0)) ? (~w_mag + OneP) : w_mag;
      w_sign_fix = w_prod_fix[2*W-1];
    end else begin
      w_prod_fix = w_mag;
      w_sign_fix = r_sign_lat && (w_mag != '0);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmt      <= 1'b0;
      r_sign_lat <= 1'b0;
      r_mcand    <= '0;
      r_mq       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_prod     <= '0;
      r_sign     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_fmt      <= bus.fmt;
            r_sign_lat <= bus.a[W-1] ^ bus.b[W-1];
            r_mcand    <= w_mag_a;
            r_mq       <= w_mag_b;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_acc_step;
          r_mq  <= w_mq_step;
          r_cnt <= r_cnt + CntW'(1);
        end
        FIX: begin
          r_prod <= w_prod_fix;
          r_sign <= w_sign_fix;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.prod = r_prod;
  assign bus.sign = r_sign;

endmodule

// File: tb/tb_seq_sign_multiplier.sv
// Self-checking bench: directed cases plus randomized operations against an integer model.
module tb_seq_sign_multiplier;
  import seq_sign_multiplier_pkg::*;

  localparam int unsigned W  = 5;
  localparam int unsigned PW = 2 * W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_sign_multiplier_if #(.W(W)) bus ();

  seq_sign_multiplier #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed integer product of the operand values as the format defines them
  function automatic void ref_mul(input logic f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                  output logic [PW-1:0] ep, output logic es);
    int va, vb, p;
    if (f == FMT_SM) begin
      va = int'(xa[W-2:0]);
      vb = int'(xb[W-2:0]);
      if (xa[W-1]) va = -va;
      if (xb[W-1]) vb = -vb;
    end else begin
      va = int'(xa);
      vb = int'(xb);
      if (xa[W-1]) va = va - (1 << W);
      if (xb[W-1]) vb = vb - (1 << W);
    end
    p = va * vb;
    if (f == FMT_SM) ep = PW'((p < 0) ? -p : p);
    else             ep = PW'(p);
    es = (p < 0);
  endfunction

  // Issue one operation at a falling edge and wait for its done pulse; returns in the done cycle
  task automatic op(input logic f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                    input bit mid_pulse, input string tag);
    logic [PW-1:0] ep;
    logic          es;
    int            k;
    int            busy_n;
    bit            seen;
    ref_mul(f, xa, xb, ep, es);
    bus.start = 1'b1;
    bus.fmt   = f;
    bus.a     = xa;
    bus.b     = xb;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.fmt   = 1'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    check_eq({tag, "_done_low_after_start"}, 32'(bus.done), 32'd0);
    k = 0;
    busy_n = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        if (mid_pulse && k == 2) begin
          bus.start = 1'b1;
          bus.fmt   = ~f;
          bus.a     = ~xa;
          bus.b     = xa;
        end
        if (mid_pulse && k == 3) bus.start = 1'b0;
        k++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(W + 1));
    check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(W + 1));
    check_eq({tag, "_busy_low_at_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_prod"}, 32'(bus.prod), 32'(ep));
    check_eq({tag, "_sign"}, 32'(bus.sign), 32'(es));
  endtask

  initial begin
    int ndone;
    int nbusy;
    bus.start = 1'b0;
    bus.fmt   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_prod", 32'(bus.prod), 32'd0);
    check_eq("reset_sign", 32'(bus.sign), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b0, 5'b10011, 5'b00101, 1'b0, "sm_m3_x_p5");
    check_eq("sm_m3_x_p5_const_prod", 32'(bus.prod), 32'd15);
    check_eq("sm_m3_x_p5_const_sign", 32'(bus.sign), 32'd1);
    @(negedge clk);

    op(1'b1, 5'b11101, 5'b00101, 1'b0, "tc_m3_x_p5");
    check_eq("tc_m3_x_p5_const_prod", 32'(bus.prod), 32'h3F1);
    check_eq("tc_m3_x_p5_const_sign", 32'(bus.sign), 32'd1);
    @(negedge clk);

    op(1'b1, 5'b10000, 5'b10000, 1'b0, "tc_min_sq");
    check_eq("tc_min_sq_const_prod", 32'(bus.prod), 32'h100);
    check_eq("tc_min_sq_const_sign", 32'(bus.sign), 32'd0);
    @(negedge clk);

    op(1'b1, 5'b01111, 5'b10000, 1'b0, "tc_max_x_min");
    check_eq("tc_max_x_min_const_prod", 32'(bus.prod), 32'h310);
    check_eq("tc_max_x_min_const_sign", 32'(bus.sign), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("hold_prod", 32'(bus.prod), 32'h310);
    check_eq("hold_sign", 32'(bus.sign), 32'd1);
    check_eq("hold_done_low", 32'(bus.done), 32'd0);

    op(1'b0, 5'b10000, 5'b00111, 1'b0, "sm_neg_zero");
    check_eq("sm_neg_zero_const_prod", 32'(bus.prod), 32'd0);
    check_eq("sm_neg_zero_const_sign", 32'(bus.sign), 32'd0);
    @(negedge clk);

    // Second start during CALC must be ignored
    op(1'b1, 5'b00110, 5'b11011, 1'b1, "mid_start_ignored");
    @(negedge clk);

    // start held in the done cycle is accepted immediately
    op(1'b0, 5'b00111, 5'b11001, 1'b0, "b2b_first");
    op(1'b1, 5'b10101, 5'b01011, 1'b0, "b2b_second");
    @(negedge clk);

    // Reset in the middle of CALC
    bus.start = 1'b1;
    bus.fmt   = 1'b1;
    bus.a     = 5'b01101;
    bus.b     = 5'b00011;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_prod", 32'(bus.prod), 32'd0);
    check_eq("midrst_sign", 32'(bus.sign), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (bus.busy) nbusy++;
    end
    check_eq("midrst_no_done_after_release", 32'(ndone), 32'd0);
    check_eq("midrst_no_busy_after_release", 32'(nbusy), 32'd0);
    op(1'b1, 5'b01101, 5'b00011, 1'b0, "after_reset");
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
